wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arb_pkg.sv | 17 +
 rtl/wb_arb_fifo.sv | 49 ++++
 rtl/wb_arbiter.sv | 159 +++++++++++++++
 tb/tb_wb_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and parameter defaults for the write-back arbiter.
package wb_arb_pkg;

  localparam int N_CH_DEF      = 3;
  localparam int NUM_PORTS_DEF = 1;
  localparam int DEPTH_DEF     = 2;
  localparam int RR_DEF        = 1;

  // One buffered execution result.
  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  dest;
    logic [4:0]  rob;
    logic        wb;
  } wb_entry_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// Per-channel result buffer: a small circular FIFO with an exposed occupancy count.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int  DEPTH   = DEPTH_DEF,
  parameter type entry_t = wb_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 din,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointers and occupancy; a flush empties the buffer regardless of push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage carries no reset; pushes are already gated off during flush.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: buffers results from N_CH sources and grants up to
// NUM_PORTS of them per cycle onto register-file write / completion ports.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N_CH      = N_CH_DEF,
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int RR        = RR_DEF
) (
  input  logic                        cpu_clock_i,
  input  logic                        cpu_resetn_i,
  input  logic                        flush_i,
  input  logic [N_CH-1:0]             src_valid_i,
  output logic [N_CH-1:0]             src_ready_o,
  input  logic [N_CH-1:0][31:0]       src_data_i,
  input  logic [N_CH-1:0][5:0]        src_dest_i,
  input  logic [N_CH-1:0][4:0]        src_rob_i,
  input  logic [N_CH-1:0]             src_wb_i,
  output logic [NUM_PORTS-1:0]        wr_en_o,
  output logic [NUM_PORTS-1:0][31:0]  wr_data_o,
  output logic [NUM_PORTS-1:0][5:0]   wr_dest_o,
  output logic [NUM_PORTS-1:0]        cmp_v_o,
  output logic [NUM_PORTS-1:0][4:0]   cmp_rob_o
);

  localparam int CH_W = $clog2(N_CH);
  localparam int CW   = $clog2(DEPTH) + 1;

  wb_entry_t             head [N_CH];
  logic [CW-1:0]         count [N_CH];
  logic [N_CH-1:0]       push;
  logic [N_CH-1:0]       pop;
  logic [N_CH-1:0]       nonempty;
  logic [CH_W-1:0]       rr_ptr;
  logic [CH_W-1:0]       rr_nxt;
  logic [CH_W:0]         start;
  logic [CH_W:0]         idx;
  logic [CH_W-1:0]       sel;
  logic                  hit;
  logic [NUM_PORTS-1:0]  gnt_v;
  logic [CH_W-1:0]       gnt_ch [NUM_PORTS];

  logic [NUM_PORTS-1:0]  vld_p1;
  wb_entry_t             ent_p1 [NUM_PORTS];
  logic [NUM_PORTS-1:0]  vld_p2;
  logic [NUM_PORTS-1:0]  en_p2;
  logic [NUM_PORTS-1:0][31:0] data_p2;
  logic [NUM_PORTS-1:0][5:0]  dest_p2;
  logic [NUM_PORTS-1:0][4:0]  rob_p2;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    wb_entry_t din;
    assign din            = {src_data_i[c], src_dest_i[c], src_rob_i[c], src_wb_i[c]};
    // Ready looks only at the registered count, so a popping full buffer still refuses.
    assign src_ready_o[c] = cpu_resetn_i && !flush_i && (count[c] < CW'(DEPTH));
    assign push[c]        = src_valid_i[c] && src_ready_o[c];
    assign nonempty[c]    = (count[c] != '0);

    wb_arb_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (wb_entry_t)
    ) u_fifo (
      .clk   (cpu_clock_i),
      .rst_n (cpu_resetn_i),
      .flush (flush_i),
      .push  (push[c]),
      .din   (din),
      .pop   (pop[c]),
      .head  (head[c]),
      .count (count[c])
    );
  end

  assign start = (RR != 0) ? {1'b0, rr_ptr} : '0;

  // Port p takes the first not-yet-granted non-empty channel in search order;
  // the highest granted port decides where the next search begins.
  always_comb begin
    gnt_v  = '0;
    pop    = '0;
    rr_nxt = rr_ptr;
    hit    = 1'b0;
    sel    = '0;
    idx    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      gnt_ch[p] = '0;
      hit       = 1'b0;
      sel       = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
        idx = start + (CH_W+1)'(i);
        if (idx >= (CH_W+1)'(N_CH)) idx = idx - (CH_W+1)'(N_CH);
        if (nonempty[idx[CH_W-1:0]] && !pop[idx[CH_W-1:0]]) begin
          hit = 1'b1;
          sel = idx[CH_W-1:0];
        end
      end
      if (hit) begin
        gnt_v[p]  = 1'b1;
        gnt_ch[p] = sel;
        pop[sel]  = 1'b1;
        rr_nxt    = (sel == CH_W'(N_CH - 1)) ? '0 : sel + CH_W'(1);
      end
    end
  end

  // Round-robin pointer.
  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i)  rr_ptr <= '0;
    else if (flush_i)   rr_ptr <= '0;
    else                rr_ptr <= rr_nxt;
  end

  // ---- stage p1: popped heads captured ----
  // Valid for the captured grants.
  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i)  vld_p1 <= '0;
    else if (flush_i)   vld_p1 <= '0;
    else                vld_p1 <= gnt_v;
  end

  // Granted head entries.
  always_ff @(posedge cpu_clock_i) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt_v[p]) ent_p1[p] <= head[gnt_ch[p]];
    end
  end

  // ---- stage p2: port output registers; payload holds when a port is idle ----
  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      vld_p2  <= '0;
      en_p2   <= '0;
      data_p2 <= '0;
      dest_p2 <= '0;
      rob_p2  <= '0;
    end else if (flush_i) begin
      vld_p2  <= '0;
      en_p2   <= '0;
    end else begin
      vld_p2 <= vld_p1;
      for (int p = 0; p < NUM_PORTS; p++) begin
        en_p2[p] <= vld_p1[p] && ent_p1[p].wb;
        if (vld_p1[p]) begin
          data_p2[p] <= ent_p1[p].data;
          dest_p2[p] <= ent_p1[p].dest;
          rob_p2[p]  <= ent_p1[p].rob;
        end
      end
    end
  end

  assign wr_en_o   = en_p2  & {NUM_PORTS{~flush_i}};
  assign cmp_v_o   = vld_p2 & {NUM_PORTS{~flush_i}};
  assign wr_data_o = data_p2;
  assign wr_dest_o = dest_p2;
  assign cmp_rob_o = rob_p2;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: three configurations share one stimulus stream and are
// each checked every cycle against a queue-based model, plus literal spot checks.
module tb_wb_arbiter;
  import wb_arb_pkg::*;

  localparam int NC = 3;
  localparam int DP = 2;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic                flush;
  logic [NC-1:0]       vld;
  logic [NC-1:0]       wb;
  logic [NC-1:0][31:0] data;
  logic [NC-1:0][5:0]  dest;
  logic [NC-1:0][4:0]  rob;

  logic [NC-1:0]  rdy_a, rdy_b, rdy_c;
  logic [0:0]     en_a, cv_a, en_c, cv_c;
  logic [1:0]     en_b, cv_b;
  logic [0:0][31:0] wd_a, wd_c;
  logic [1:0][31:0] wd_b;
  logic [0:0][5:0]  wdst_a, wdst_c;
  logic [1:0][5:0]  wdst_b;
  logic [0:0][4:0]  crob_a, crob_c;
  logic [1:0][4:0]  crob_b;

  wb_arbiter #(.N_CH(3), .NUM_PORTS(1), .DEPTH(2), .RR(1)) dut_a (
    .cpu_clock_i(clk), .cpu_resetn_i(rst_n), .flush_i(flush),
    .src_valid_i(vld), .src_ready_o(rdy_a), .src_data_i(data), .src_dest_i(dest),
    .src_rob_i(rob), .src_wb_i(wb), .wr_en_o(en_a), .wr_data_o(wd_a),
    .wr_dest_o(wdst_a), .cmp_v_o(cv_a), .cmp_rob_o(crob_a));

  wb_arbiter #(.N_CH(3), .NUM_PORTS(2), .DEPTH(2), .RR(1)) dut_b (
    .cpu_clock_i(clk), .cpu_resetn_i(rst_n), .flush_i(flush),
    .src_valid_i(vld), .src_ready_o(rdy_b), .src_data_i(data), .src_dest_i(dest),
    .src_rob_i(rob), .src_wb_i(wb), .wr_en_o(en_b), .wr_data_o(wd_b),
    .wr_dest_o(wdst_b), .cmp_v_o(cv_b), .cmp_rob_o(crob_b));

  wb_arbiter #(.N_CH(3), .NUM_PORTS(1), .DEPTH(2), .RR(0)) dut_c (
    .cpu_clock_i(clk), .cpu_resetn_i(rst_n), .flush_i(flush),
    .src_valid_i(vld), .src_ready_o(rdy_c), .src_data_i(data), .src_dest_i(dest),
    .src_rob_i(rob), .src_wb_i(wb), .wr_en_o(en_c), .wr_data_o(wd_c),
    .wr_dest_o(wdst_c), .cmp_v_o(cv_c), .cmp_rob_o(crob_c));

  // Uniform two-port views of every instance.
  logic [NC-1:0]    o_rdy  [NI];
  logic [1:0]       o_en   [NI];
  logic [1:0]       o_cv   [NI];
  logic [1:0][31:0] o_wd   [NI];
  logic [1:0][5:0]  o_dst  [NI];
  logic [1:0][4:0]  o_rob  [NI];

  always_comb begin
    o_rdy[0] = rdy_a;            o_rdy[1] = rdy_b;  o_rdy[2] = rdy_c;
    o_en[0]  = {1'b0, en_a};     o_en[1]  = en_b;   o_en[2]  = {1'b0, en_c};
    o_cv[0]  = {1'b0, cv_a};     o_cv[1]  = cv_b;   o_cv[2]  = {1'b0, cv_c};
    o_wd[0]  = {32'h0, wd_a};    o_wd[1]  = wd_b;   o_wd[2]  = {32'h0, wd_c};
    o_dst[0] = {6'h0, wdst_a};   o_dst[1] = wdst_b; o_dst[2] = {6'h0, wdst_c};
    o_rob[0] = {5'h0, crob_a};   o_rob[1] = crob_b; o_rob[2] = {5'h0, crob_c};
  end

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  wb_entry_t  mq   [NI*NC][$];
  int         m_rr [NI];
  logic [1:0] m_v1 [NI];
  logic [1:0] m_v2 [NI];
  wb_entry_t  m_e1 [NI][2];
  wb_entry_t  m_e2 [NI][2];

  function automatic int np_of(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic int rr_of(input int i);
    return (i == 2) ? 0 : 1;
  endfunction

  task automatic model_clear(input int i, input bit full);
    for (int c = 0; c < NC; c++) mq[i*NC+c].delete();
    m_rr[i] = 0;
    m_v1[i] = '0;
    m_v2[i] = '0;
    if (full) for (int k = 0; k < 2; k++) m_e2[i][k] = '0;
  endtask

  task automatic model_edge();
    int sz [NC];
    int start, cnt, last, c;
    logic [1:0] nv;
    wb_entry_t e;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) model_clear(i, 1'b1);
      else if (flush) model_clear(i, 1'b0);
      else begin
        for (int k = 0; k < 2; k++) begin
          m_v2[i][k] = m_v1[i][k];
          if (m_v1[i][k]) m_e2[i][k] = m_e1[i][k];
        end
        for (int c2 = 0; c2 < NC; c2++) sz[c2] = mq[i*NC+c2].size();
        start = (rr_of(i) != 0) ? m_rr[i] : 0;
        cnt = 0; last = -1; nv = '0;
        for (int j = 0; j < NC; j++) begin
          c = (start + j) % NC;
          if (sz[c] > 0 && cnt < np_of(i)) begin
            m_e1[i][cnt] = mq[i*NC+c].pop_front();
            nv[cnt[0]] = 1'b1;
            cnt++;
            last = c;
          end
        end
        m_v1[i] = nv;
        if (last >= 0) m_rr[i] = (last + 1) % NC;
        for (int c2 = 0; c2 < NC; c2++) begin
          if (vld[c2] && sz[c2] < DP) begin
            e.data = data[c2]; e.dest = dest[c2]; e.rob = rob[c2]; e.wb = wb[c2];
            mq[i*NC+c2].push_back(e);
          end
        end
      end
    end
  endtask

  // Every-cycle comparison of all instances against the model.
  initial begin
    logic [NC-1:0] er;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        for (int c = 0; c < NC; c++)
          er[c] = rst_n && !flush && (mq[i*NC+c].size() < DP);
        cmp($sformatf("ready[%0d]", i), 64'(o_rdy[i]), 64'(er));
        for (int k = 0; k < np_of(i); k++) begin
          cmp($sformatf("wr_en[%0d][%0d]", i, k), 64'(o_en[i][k]),
              64'(m_v2[i][k] & m_e2[i][k].wb & !flush));
          cmp($sformatf("cmp_v[%0d][%0d]", i, k), 64'(o_cv[i][k]), 64'(m_v2[i][k] & !flush));
          cmp($sformatf("wr_data[%0d][%0d]", i, k), 64'(o_wd[i][k]), 64'(m_e2[i][k].data));
          cmp($sformatf("wr_dest[%0d][%0d]", i, k), 64'(o_dst[i][k]), 64'(m_e2[i][k].dest));
          cmp($sformatf("cmp_rob[%0d][%0d]", i, k), 64'(o_rob[i][k]), 64'(m_e2[i][k].rob));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) model_clear(i, 1'b1);
  endtask

  task automatic pulse_reset();
    vld = '0; flush = 1'b0;
    assert_reset();
    tick();
    rst_n = 1'b1;
  endtask

  int seq [NC];
  int drops;
  logic [NC-1:0] acc;

  initial begin
    rst_n = 1'b0; flush = 1'b0; vld = '0; wb = '0;
    data = '0; dest = '0; rob = '0;
    for (int i = 0; i < NI; i++) model_clear(i, 1'b1);
    #1;
    cmp("reset_ready", 64'(rdy_a), 64'(0));
    cmp("reset_cv", 64'(cv_a), 64'(0));
    tick(); tick();
    rst_n = 1'b1;
    #1;
    cmp("release_ready", 64'(rdy_a), 64'(3'b111));
    tick();

    // Single result through ch1: two-cycle latency, one-cycle pulse.
    vld = 3'b010; data[1] = 32'hDEADBEEF; dest[1] = 6'd12; rob[1] = 5'd7; wb[1] = 1'b1;
    tick();
    vld = '0;
    tick();
    cmp("lat_t1_en", 64'(en_a), 64'(0));
    tick();
    cmp("lat_t2_en", 64'(en_a), 64'(1));
    cmp("lat_t2_data", 64'(wd_a), 64'(32'hDEADBEEF));
    cmp("lat_t2_dest", 64'(wdst_a), 64'(12));
    cmp("lat_t2_cv", 64'(cv_a), 64'(1));
    cmp("lat_t2_rob", 64'(crob_a), 64'(7));
    tick();
    cmp("pulse_en", 64'(en_a), 64'(0));
    cmp("pulse_cv", 64'(cv_a), 64'(0));
    cmp("hold_data", 64'(wd_a), 64'(32'hDEADBEEF));

    // Completion-only entry.
    vld = 3'b001; wb[0] = 1'b0; rob[0] = 5'd3; data[0] = 32'h1234;
    tick();
    vld = '0;
    tick(); tick();
    cmp("nowb_cv", 64'(cv_a), 64'(1));
    cmp("nowb_rob", 64'(crob_a), 64'(3));
    cmp("nowb_en", 64'(en_a), 64'(0));

    // Round-robin over a full contended round, twice.
    pulse_reset();
    for (int r = 0; r < 2; r++) begin
      vld = 3'b111; wb = 3'b111;
      for (int c = 0; c < NC; c++) rob[c] = 5'(20 + 3*r + c);
      tick();
      vld = '0;
      tick(); tick();
      cmp("rr_first", 64'(crob_a), 64'(20 + 3*r));
      if (r == 0) begin
        cmp("two_port_v", 64'(cv_b), 64'(2'b11));
        cmp("two_port_rob", 64'(crob_b), 64'({5'd21, 5'd20}));
      end
      tick();
      cmp("rr_second", 64'(crob_a), 64'(21 + 3*r));
      tick();
      cmp("rr_third", 64'(crob_a), 64'(22 + 3*r));
    end

    // Fixed priority revisits ch0 while round-robin moves on.
    pulse_reset();
    vld = 3'b111;
    for (int c = 0; c < NC; c++) rob[c] = 5'(c);
    tick();
    for (int c = 0; c < NC; c++) rob[c] = 5'(c + 4);
    tick();
    vld = '0;
    tick(); tick();
    cmp("prio_rr_rob", 64'(crob_a), 64'(1));
    cmp("prio_fixed_rob", 64'(crob_c), 64'(4));

    // Two ports, sparse channels.
    pulse_reset();
    vld = 3'b101; rob[0] = 5'd5; rob[2] = 5'd9;
    tick();
    vld = '0;
    tick(); tick();
    cmp("sparse_v", 64'(cv_b), 64'(2'b11));
    cmp("sparse_rob", 64'(crob_b), 64'({5'd9, 5'd5}));

    // Continuous streaming on all channels.
    pulse_reset();
    for (int c = 0; c < NC; c++) seq[c] = 0;
    drops = 0;
    for (int n = 0; n < 40; n++) begin
      vld = 3'b111;
      for (int c = 0; c < NC; c++) begin
        rob[c] = 5'(c*10 + seq[c] % 10);
        data[c] = $urandom;
        wb[c] = 1'($urandom);
      end
      acc = vld & rdy_a;
      if (rdy_a != 3'b111) drops++;
      tick();
      for (int c = 0; c < NC; c++) if (acc[c]) seq[c]++;
      if (n >= 2) cmp("stream_valid", 64'(cv_a), 64'(1));
    end
    cmp("stream_ready_drops", 64'(drops > 0), 64'(1));
    vld = '0;

    // Flush with entries buffered and an output live.
    pulse_reset();
    vld = 3'b111;
    tick(); tick(); tick();
    vld = '0;
    flush = 1'b1;
    #1;
    cmp("flush_en", 64'(en_a), 64'(0));
    cmp("flush_cv", 64'(cv_a), 64'(0));
    cmp("flush_ready", 64'(rdy_a), 64'(0));
    tick();
    flush = 1'b0;
    #1;
    cmp("post_flush_ready", 64'(rdy_a), 64'(3'b111));
    for (int n = 0; n < 3; n++) begin
      tick();
      cmp("post_flush_cv", 64'(cv_a), 64'(0));
      cmp("post_flush_cv_b", 64'(cv_b), 64'(0));
    end

    // Same, with reset pulsed instead of flush.
    vld = 3'b111;
    tick(); tick(); tick();
    vld = '0;
    assert_reset();
    #1;
    cmp("rst_en", 64'(en_a), 64'(0));
    cmp("rst_cv", 64'(cv_a), 64'(0));
    cmp("rst_data", 64'(wd_a), 64'(0));
    cmp("rst_dest", 64'(wdst_a), 64'(0));
    cmp("rst_rob", 64'(crob_a), 64'(0));
    cmp("rst_ready", 64'(rdy_a), 64'(0));
    tick();
    rst_n = 1'b1;
    #1;
    cmp("rel_ready", 64'(rdy_a), 64'(3'b111));
    cmp("rel_cv", 64'(cv_a), 64'(0));
    for (int n = 0; n < 3; n++) begin
      tick();
      cmp("rel_no_output", 64'(cv_a), 64'(0));
    end

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 3000; n++) begin
      vld   = (n % 500 < 250) ? NC'($urandom) : NC'($urandom & $urandom);
      wb    = NC'($urandom);
      flush = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < NC; c++) begin
        data[c] = $urandom;
        dest[c] = 6'($urandom);
        rob[c]  = 5'($urandom);
      end
      if ($urandom_range(0, 499) == 0) begin
        flush = 1'b0;
        pulse_reset();
      end else begin
        tick();
      end
    end
    vld = '0; flush = 1'b0;
    tick(); tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
